// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - issue/result bundle between the pipeline controller and the multiply/divide unit
//
// Purpose: groups the MDU issue strobe, operation select, operands, busy
// flag and HI/LO/read-result outputs into one bundle.
// Ports (signals):
//   start    issue strobe, sampled with MDU_op/A/B on the rising clock edge
//   MDU_op   4-bit operation select
//   A, B     WIDTH-bit operands (rs, rt)
//   busy     high while a multi-cycle operation is in flight
//   HI, LO   architectural HI/LO registers
//   MDU_out  combinational mfhi/mflo read result
// Modports: master (pipeline side drives the issue), slave (the MDU).

interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       MDU_op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] MDU_out;

    modport master (
        output start, MDU_op, A, B,
        input  busy, HI, LO, MDU_out
    );

    modport slave (
        input  start, MDU_op, A, B,
        output busy, HI, LO, MDU_out
    );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding the HI/LO register pair
//
// Purpose: executes mult/multu/div/divu (and optionally madd/maddu/msub/msubu)
// with a fixed, parameterised latency, plus mthi/mtlo writes and
// combinational mfhi/mflo reads.
// Parameters:
//   WIDTH        operand and HI/LO width (even, >= 4)
//   MULT_CYCLES  busy cycles for multiply/accumulate ops (1..63)
//   DIV_CYCLES   busy cycles for divide ops (1..63)
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    mdu_if.slave: start, MDU_op, A, B in; busy, HI, LO, MDU_out out
// Optional feature macro: MDU_MADD_EN enables ops 9..12 (multiply-accumulate).

module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);
    localparam int W = WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q;
    logic [5:0]     cnt_q;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic           busy_q;

    // Issue decode on the incoming op
    logic is_arith;
    logic is_div;

    always_comb begin
        is_div   = (bus.MDU_op == OP_DIV) || (bus.MDU_op == OP_DIVU);
        is_arith = (bus.MDU_op == OP_MULT) || (bus.MDU_op == OP_MULTU) || is_div;
`ifdef MDU_MADD_EN
        if ((bus.MDU_op == OP_MADD) || (bus.MDU_op == OP_MADDU) ||
            (bus.MDU_op == OP_MSUB) || (bus.MDU_op == OP_MSUBU)) begin
            is_arith = 1'b1;
        end
`endif
    end

    // Multiplier on the latched operands; signed ops sign-extend to 2W so the
    // low 2W bits of the product are the two's-complement result.
    logic           mul_signed;
    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] prod;

    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MSUB)) begin
            mul_signed = 1'b1;
        end
`endif
        a_ext = {{W{mul_signed & a_q[W-1]}}, a_q};
        b_ext = {{W{mul_signed & b_q[W-1]}}, b_q};
        prod  = a_ext * b_ext;
    end

    // Divider works on magnitudes and fixes signs afterwards, giving
    // truncation toward zero and a remainder with the dividend's sign.
    // The -2^(W-1) / -1 case falls out naturally: magnitude 2^(W-1) / 1
    // with no quotient negation yields LO = -2^(W-1), HI = 0.
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] b_safe;
    logic [W-1:0] q_mag;
    logic [W-1:0] r_mag;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         div_zero;

    always_comb begin
        a_neg    = (op_q == OP_DIV) && a_q[W-1];
        b_neg    = (op_q == OP_DIV) && b_q[W-1];
        a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
        b_mag    = b_neg ? (~b_q + 1'b1) : b_q;
        div_zero = (b_q == '0);
        // Keep the divider well defined on /0; the result is discarded then.
        b_safe   = div_zero ? {{(W-1){1'b0}}, 1'b1} : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quo      = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem      = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    // Completion result and write enable for the final RUN cycle
    logic           res_wr;
    logic [2*W-1:0] res;

    always_comb begin
        res_wr = 1'b1;
        res    = {hi_q, lo_q};
        case (op_q)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV, OP_DIVU: begin
                res    = {rem, quo};
                res_wr = !div_zero;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: res = {hi_q, lo_q} + prod;
            OP_MSUB, OP_MSUBU: res = {hi_q, lo_q} - prod;
`endif
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (is_arith) begin
                            a_q     <= bus.A;
                            b_q     <= bus.B;
                            op_q    <= bus.MDU_op;
                            cnt_q   <= is_div ? 6'(DIV_CYCLES) : 6'(MULT_CYCLES);
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else if (bus.MDU_op == OP_MTHI) begin
                            hi_q <= bus.A;
                        end else if (bus.MDU_op == OP_MTLO) begin
                            lo_q <= bus.A;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        if (res_wr) begin
                            hi_q <= res[2*W-1:W];
                            lo_q <= res[W-1:0];
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign bus.MDU_out = (bus.MDU_op == OP_MFHI) ? hi_q :
                         (bus.MDU_op == OP_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu

module tb_mdu;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   cyc;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the issue edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.MDU_op = op;
        bus.A      = a;
        bus.B      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.MDU_op = 4'd0;
        bus.A      = 32'hDEAD_BEEF;
        bus.B      = 32'h1234_5678;
    endtask

    // Counts busy cycles; returns at the first falling edge with busy low.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.MDU_op = 4'd0;
        bus.A      = '0;
        bus.B      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_hilo", {bus.HI, bus.LO}, 64'd0);

        // signed mult -2*3; MDU_out shows stale LO during busy
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy_rise", {63'd0, bus.busy}, 64'd1);
        bus.MDU_op = 4'd6;
        #1;
        check("mflo_stale", {32'd0, bus.MDU_out}, 64'd0);
        bus.MDU_op = 4'd0;
        wait_idle(cyc);
        check("mult_cycles", 64'(cyc), 64'd5);
        check("mult_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        bus.MDU_op = 4'd5;
        #1;
        check("mfhi", {32'd0, bus.MDU_out}, 64'h0000_0000_FFFF_FFFF);
        bus.MDU_op = 4'd0;

        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        wait_idle(cyc);
        check("multu_hilo", {bus.HI, bus.LO}, 64'h0000_0002_FFFF_FFFA);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        check("div_cycles", 64'(cyc), 64'd10);
        check("div_neg7_2", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(4'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(cyc);
        check("div_7_neg2", {bus.HI, bus.LO}, 64'h0000_0001_FFFF_FFFD);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        check("div_overflow", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);

        issue(4'd4, 32'd100, 32'd7);
        wait_idle(cyc);
        check("divu_100_7", {bus.HI, bus.LO}, 64'h0000_0002_0000_000E);

        // mthi/mtlo then divide by zero keeps HI/LO
        issue(4'd7, 32'h11, 32'd0);
        check("mthi_nobusy", {63'd0, bus.busy}, 64'd0);
        issue(4'd8, 32'h22, 32'd0);
        check("mthi_mtlo", {bus.HI, bus.LO}, 64'h0000_0011_0000_0022);
        issue(4'd4, 32'd7, 32'd0);
        wait_idle(cyc);
        check("divu0_cycles", 64'(cyc), 64'd10);
        check("divu0_hilo", {bus.HI, bus.LO}, 64'h0000_0011_0000_0022);

        // mfhi with start and undefined op: no state effect
        issue(4'd5, 32'h99, 32'd0);
        issue(4'd13, 32'h99, 32'd1);
        check("noop_busy", {63'd0, bus.busy}, 64'd0);
        check("noop_hilo", {bus.HI, bus.LO}, 64'h0000_0011_0000_0022);

        // back-to-back with no bubble
        issue(4'd2, 32'd5, 32'd6);
        wait_idle(cyc);
        check("b2b_first", {bus.HI, bus.LO}, 64'd30);
        issue(4'd1, 32'd2, 32'd3);
        wait_idle(cyc);
        check("b2b_cycles", 64'(cyc), 64'd5);
        check("b2b_second", {bus.HI, bus.LO}, 64'd6);

        // start while busy is ignored, reset aborts
        issue(4'd1, 32'd4, 32'd5);
        issue(4'd8, 32'h55, 32'd0);
        check("mtlo_ignored", {32'd0, bus.LO}, 64'd6);
        check("busy_cycle3", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hilo", {bus.HI, bus.LO}, 64'd0);

        // multiply-accumulate path
        issue(4'd8, 32'd10, 32'd0);
        issue(4'd7, 32'd0, 32'd0);
        issue(4'd9, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        check("madd_busy", {63'd0, bus.busy}, 64'd1);
        wait_idle(cyc);
        check("madd_cycles", 64'(cyc), 64'd5);
        check("madd_hilo", {bus.HI, bus.LO}, 64'd22);
        issue(4'd11, 32'd5, 32'd5);
        wait_idle(cyc);
        check("msub_wrap", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        check("madd_busy", {63'd0, bus.busy}, 64'd0);
        wait_idle(cyc);
        check("madd_hilo", {bus.HI, bus.LO}, 64'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit for the next-generation MIPS datapath. It holds the HI/LO register pair and executes mult/multu/div/divu with configurable latency. It exposes a busy flag so the pipeline controller can stall any following MDU instruction. It sits beside the ALU in the execute stage: operands come from RF read ports 1/2, and mfhi/mflo results feed the RF write-data mux.

## Interface
- WIDTH, 32: operand and HI/LO width in bits; must be even and ≥ 4.
- MULT_CYCLES, 5: busy cycles for a multiply; legal range 1–63.
- DIV_CYCLES, 10: busy cycles for a divide; legal range 1–63.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe; op, A and B are sampled on the same edge.
- MDU_op  in  4  operation select:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9 madd, 10 maddu, 11 msub, 12 msubu
- A  in  WIDTH  operand rs (RF_RD1).
- B  in  WIDTH  operand rt (RF_RD2).
- busy  out  1  high while an operation is in flight.
- HI  out  WIDTH  architectural HI register.
- LO  out  WIDTH  architectural LO register.
- MDU_out  out  WIDTH  combinational read result: HI for op 5, LO for op 6, otherwise 0.

## Operation
- States are IDLE and RUN. A down-counter of width 6 runs in RUN.
- IDLE + start with an arithmetic op (1–4, or 9–12 when enabled):
  - latch the operands and the op;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN: the counter decrements each cycle. When the counter reads 1:
  - HI/LO are written with the result;
  - the state returns to IDLE.
- mult/multu: {HI,LO} = A×B as a 2·WIDTH-bit product, signed or unsigned respectively.
- div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Signed overflow, −2^(WIDTH−1)/−1: LO = −2^(WIDTH−1), HI = 0.
- Divide by zero: the unit still spends DIV_CYCLES busy; HI/LO are left unchanged.
- mthi/mtlo with start in IDLE: HI or LO = A on that edge. busy is not raised.
- mfhi/mflo: purely combinational on MDU_out. Asserting start with these ops has no state effect.
- Any start while busy is ignored, including mthi/mtlo. The stall logic must hold the instruction until busy falls.
- start with op 0 or an undefined op (13–15, or 9–12 when disabled) does nothing.
- Operand latching: A and B changing after the start edge do not affect the result.

## Timing
- Reset: HI = 0, LO = 0, busy = 0, state IDLE, counter 0.
- Reset mid-operation: the operation is aborted, HI/LO are cleared, and busy falls on that edge.
- start sampled at edge T:
  - busy = 1 from after edge T;
  - busy remains high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES);
  - HI/LO update at edge T+N, in the same edge where busy falls.
- start may be reasserted in the first cycle busy is low, giving back-to-back operations with no bubble.
- MDU_out has zero latency from MDU_op. During busy it reflects the stale HI/LO.
- mthi/mtlo: one-cycle write, visible on HI/LO after the edge.

## Configuration
- MDU_MADD_EN defined: ops 9–12 are legal and use MULT_CYCLES.
  - madd/maddu: {HI,LO} += A×B (signed or unsigned product).
  - msub/msubu: {HI,LO} −= A×B.
  - Accumulation wraps modulo 2^(2·WIDTH).
- MDU_MADD_EN undefined: ops 9–12 behave as op 0 (no busy, no state change). The accumulate datapath is not synthesised.

## Test plan
- Reset, then mult with A=0xFFFFFFFE, B=3 → busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at busy fall.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div with A=−7, B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with A=7, B=0 after mthi 0x11 / mtlo 0x22 → busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- mult issued, then mtlo 0x55 with start asserted while busy, then reset at busy cycle 3:
  - the mtlo is ignored;
  - after reset, busy=0 and HI=LO=0 on that edge.
- With MDU_MADD_EN: mtlo 10, mthi 0, madd A=3, B=4 → LO=22, HI=0.
- Without MDU_MADD_EN: the same sequence gives LO=10, busy never rises.
